// File: rtl/mips_defs_pkg.sv
// Definitions shared by the fetch unit and the IF/ID register:
// ExcCodes, the NOP encoding and the instruction memory map.
package mips_defs_pkg;

  localparam logic [4:0]  EXC_NONE   = 5'd0;
  localparam logic [4:0]  EXC_ADEL   = 5'd4;
  localparam logic [31:0] NOP        = 32'h0000_0000;

  localparam logic [31:0] PC_RESET   = 32'h0000_3000;
  localparam logic [31:0] IMEM_BASE  = 32'h0000_3000;
  localparam logic [31:0] IMEM_BYTES = 32'h0000_4000;

endpackage

// File: rtl/sat_counter.sv
// Synchronous up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (clr)
      count_q <= '0;
    else if (inc && (count_q != '1))
      count_q <= count_q + 1'b1;
  end

  assign count = count_q;

endmodule

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: latches the fetch PC/instruction, holds on stall,
// bubbles on flush, flags fetch address faults and tracks perf counters.
module if_id_reg
  import mips_defs_pkg::*;
#(
  parameter logic [31:0] PC_RESET_VAL = PC_RESET,
  parameter logic [31:0] IMEM_LO      = IMEM_BASE,
  parameter logic [31:0] IMEM_SIZE    = IMEM_BYTES,
  parameter logic [4:0]  EXC_FAULT    = EXC_ADEL
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        d_is_jb,
  input  logic [31:0] f_pc,
  input  logic [31:0] f_instr,
  output logic [31:0] d_pc,
  output logic [31:0] d_instr,
  output logic        d_valid,
  output logic [4:0]  d_exc_code,
  output logic        d_bd,
  output logic [31:0] cnt_fetched,
  output logic [31:0] cnt_stall
);

  // Upper bound kept at 33 bits so a map ending at 4 GiB does not wrap to 0.
  localparam logic [32:0] IMEM_HI = {1'b0, IMEM_LO} + {1'b0, IMEM_SIZE};

  logic fault;
  logic load;

  assign fault = (f_pc[1:0] != 2'b00) || (f_pc < IMEM_LO) || ({1'b0, f_pc} >= IMEM_HI);
  assign load  = !flush && !stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      d_pc       <= PC_RESET_VAL;
      d_instr    <= NOP;
      d_valid    <= 1'b0;
      d_exc_code <= EXC_NONE;
      d_bd       <= 1'b0;
    end else if (flush) begin
      d_pc       <= f_pc;
      d_instr    <= NOP;
      d_valid    <= 1'b0;
      d_exc_code <= EXC_NONE;
      d_bd       <= 1'b0;
    end else if (load) begin
      d_pc       <= f_pc;
      d_valid    <= 1'b1;
      d_bd       <= d_is_jb;
      d_instr    <= fault ? NOP : f_instr;
      d_exc_code <= fault ? EXC_FAULT : EXC_NONE;
    end
  end

  sat_counter #(.WIDTH(32)) u_fetch_cnt (
    .clk   (clk),
    .clr   (reset),
    .inc   (load),
    .count (cnt_fetched)
  );

  sat_counter #(.WIDTH(32)) u_stall_cnt (
    .clk   (clk),
    .clr   (reset),
    .inc   (stall && !flush),
    .count (cnt_stall)
  );

endmodule
